// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, valid/ready imem request, delayed redirect, one-entry IF/ID buffer.
// Optional build macro FETCH_ADEL_EN enables the fetch address-error check.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc4,
  output logic [31:0] if_instr,
  output logic        if_adel
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] pend_pc_reg;
  logic        if_valid_reg;
  logic [31:0] if_pc4_reg;
  logic [31:0] if_instr_reg;
  logic        req_cond;
  logic        fire;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_reg + 32'd4;

`ifdef FETCH_ADEL_EN
  // 33-bit limit so a window reaching the top of the address space does not overflow.
  localparam logic [32:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2);

  logic pc_illegal;
  logic if_adel_reg;

  assign pc_illegal = (pc_reg[1:0] != 2'b00) || (pc_reg < IMEM_BASE) ||
                      ({1'b0, pc_reg} >= IMEM_LIMIT);
  assign if_adel    = if_adel_reg;
`else
  localparam logic [31:0] CFG_UNUSED = IMEM_BASE ^ 32'(IMEM_WORDS);
  assign if_adel = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= BOOT;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     if (redirect && !fire) state_next = PEND;
      PEND:    if (fire) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Request / fire outputs; an illegal PC "fires" without touching memory.
  always_comb begin
    req_cond = (state_reg != BOOT) && (!if_valid_reg || !stall);
`ifdef FETCH_ADEL_EN
    imem_req = req_cond && !pc_illegal;
    fire     = req_cond && (pc_illegal || imem_ready);
`else
    imem_req = req_cond;
    fire     = req_cond && imem_ready;
`endif
  end

  assign imem_addr = pc_reg;
  assign if_valid  = if_valid_reg;
  assign if_pc4    = if_pc4_reg;
  assign if_instr  = if_instr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= RESET_PC;
      pend_pc_reg  <= '0;
      if_valid_reg <= 1'b0;
      if_pc4_reg   <= '0;
      if_instr_reg <= '0;
`ifdef FETCH_ADEL_EN
      if_adel_reg  <= 1'b0;
`endif
    end else begin
      if (fire) begin
        if_valid_reg <= 1'b1;
        if_pc4_reg   <= pc_plus4;
`ifdef FETCH_ADEL_EN
        if_instr_reg <= pc_illegal ? 32'd0 : imem_rdata;
        if_adel_reg  <= pc_illegal;
`else
        if_instr_reg <= imem_rdata;
`endif
      end else if (!stall) begin
        if_valid_reg <= 1'b0;
      end

      // The delay slot at pc always goes out before the redirect target.
      if (fire) begin
        if (state_reg == PEND) pc_reg <= pend_pc_reg;
        else if (redirect)     pc_reg <= redirect_pc;
        else                   pc_reg <= pc_plus4;
      end else if (state_reg == RUN && redirect) begin
        pend_pc_reg <= redirect_pc;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that consumes the next-PC value produced by the branch/jump target logic and drives instruction memory. It owns the PC register, issues one word request per instruction over a valid/ready handshake, and applies decode-stage redirects after the branch delay slot. It presents each fetched instruction, with its PC+4, to decode through a one-entry IF/ID buffer that honours the hazard-unit stall.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, first fetch address after reset
- `IMEM_BASE`, 32'h0000_3000, lowest legal fetch address (used only with `FETCH_ADEL_EN`)
- `IMEM_WORDS`, 1024, number of legal instruction words from `IMEM_BASE` (used only with `FETCH_ADEL_EN`)

Ports:
- `clk` in 1: single clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `stall` in 1: decode is stalled; IF/ID buffer must hold
- `redirect` in 1: one-cycle pulse; the branch/jump in decode is taken
- `redirect_pc` in 32: target from the next-PC logic, valid with `redirect`
- `imem_req` out 1: fetch request valid
- `imem_addr` out 32: word address of the request, equal to the PC
- `imem_ready` in 1: memory accepts the request; `imem_rdata` is valid in the same cycle
- `imem_rdata` in 32: instruction word
- `if_valid` out 1: IF/ID buffer holds an instruction
- `if_pc4` out 32: PC+4 of the buffered instruction
- `if_instr` out 32: buffered instruction
- `if_adel` out 1: buffered entry is an address-error fetch; always 0 without `FETCH_ADEL_EN`

## Operation
- The FSM has three states:
  - BOOT: entered on reset. No request. Goes to RUN after one cycle.
  - RUN: normal fetching.
  - PEND: a redirect is latched and waits for the delay-slot fetch to complete.
- Fetch fires when `imem_req && imem_ready`.
- `imem_req = (state != BOOT) && (!if_valid || !stall)`. `imem_addr = pc` at all times.
- When a fetch fires:
  - `if_instr <= imem_rdata`, `if_pc4 <= pc + 4`, `if_valid <= 1`.
  - In RUN with no `redirect`: `pc <= pc + 4`.
  - In RUN with `redirect`: `pc <= redirect_pc`.
  - In PEND: `pc <= pend_pc`, then go to RUN.
- Redirect while no fetch fires, in RUN: `pend_pc <= redirect_pc`, go to PEND, pc holds. The delay slot at `pc` is therefore always fetched before the target.
- Redirect in PEND is a protocol violation. It is ignored, and the bench asserts that it never occurs.
- No fetch fires and `stall == 0`: `if_valid <= 0`, which inserts a bubble.
- `stall == 1`: all `if_*` outputs hold.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
- Reset in any state drops the pending redirect and any buffered entry. All outputs return to their reset values.

## Timing
- Reset values:
  - pc = `RESET_PC`, state = BOOT.
  - `if_valid` = 0, `if_pc4` = 0, `if_instr` = 0, `if_adel` = 0.
  - `imem_req` = 0.
  - `pend_pc` = 0.
- The first `imem_req` is asserted in the second cycle after `reset` deasserts (the BOOT cycle comes first).
- Latency: data accepted in cycle N appears on `if_*` after the edge ending cycle N.
- With memory ready every cycle and no stall, throughput is one instruction per cycle.
- A redirect in cycle N with a fetch firing in N puts the target on `imem_addr` in cycle N+1.
- `redirect` and `stall` high together: the redirect is still accepted (latched into pc or `pend_pc`). Only the `if_*` outputs hold.

## Configuration
- `FETCH_ADEL_EN` defined:
  - A PC is illegal if `pc[1:0] != 0`, or if `pc` is outside `[IMEM_BASE, IMEM_BASE + 4*IMEM_WORDS)`.
  - For an illegal PC, `imem_req` stays 0. The fetch is treated as firing internally whenever the request condition holds.
  - The buffer then loads `if_instr = 0` (nop), `if_pc4 = pc + 4`, `if_adel = 1`. PC and FSM advance as for a real fetch.
- `FETCH_ADEL_EN` undefined: no address check, and `if_adel` is constant 0.

## Test plan
- Reset, `imem_ready` = 1, no stall:
  - `imem_addr` sequence is 0x3000, 0x3004, 0x3008.
  - `if_pc4` is 0x3004 one cycle after the first request.
- Redirect to 0x3100 in the cycle that 0x3008 fires:
  - Next `imem_addr` = 0x3100.
  - `if_pc4` sequence includes 0x300C (delay slot) and then 0x3104.
- Redirect to 0x3200 while `imem_ready` = 0 at 0x300C (enters PEND); `ready` returns 2 cycles later:
  - 0x300C fetches first, then 0x3200.
- `stall` held 3 cycles with a valid buffer:
  - `if_*` stable, `imem_req` = 0.
  - On release, the next fetch resumes at the held pc.
- Redirect to 0x0000_3002 with `FETCH_ADEL_EN`:
  - `imem_req` stays 0 at that address.
  - `if_adel` = 1, `if_instr` = 0, `if_pc4` = 0x3006.
- Assert `reset` while in PEND:
  - Pending target is lost.
  - The first fetch after the BOOT cycle is at 0x3000.
